bnn_window_reader: RTL and testbench
====================================

Name: bnn_window_reader

Overview:
- Read-side counterpart of the serial pixel/weight register loader.
- Once the loader has filled the binary 28x28 pixel array, this block scans it in raster order. It emits one KxK binary window per handshake to the layer-1 convolution datapath.
- Sits between the pixel register bank and layer 1. Started by the top FSM on entry to the layer-1 state; its done pulse drives the FSM's layer-1-done input.

Parameters:
- IMG_H, 28, image rows.
- IMG_W, 28, image columns.
- K, 3, window edge length (odd, >=3).

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  single-cycle pulse; begins a scan when idle.
- pixels  input  IMG_H*IMG_W  flattened pixel array; bit r*IMG_W+c = pixel(r,c). Must be held stable while busy.
- win_ready  input  1  consumer accepts the current window.
- win_valid  output  1  win/win_row/win_col hold a valid window.
- win  output  K*K  window bits; win[K*i+j] = pixel(row+i, col+j), i,j in 0..K-1.
- win_row  output  $clog2(IMG_H)  output-row index of the window.
- win_col  output  $clog2(IMG_W)  output-column index of the window.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  single-cycle pulse after the last window is accepted.

Behaviour:
- Output grid (no padding): OUT_H = IMG_H-K+1, OUT_W = IMG_W-K+1, i.e. 26x26 = 676 windows for defaults.
- Reset (async, any time, including mid-scan): state IDLE; win_valid, busy, done = 0; win, win_row, win_col = 0; counters = 0.
- FSM states:
  - IDLE: start=1 -> SCAN. Load window (0,0) into the output registers; win_valid=1 and busy=1 from the next cycle (latency 1).
  - SCAN: the handshake is win_valid&&win_ready.
    - Handshake, not last window: advance col. On col==OUT_W-1, wrap col to 0 and increment row. The next window is registered and win_valid stays 1, giving 1 window/cycle under full ready.
    - No handshake: win, win_row and win_col hold exactly; win_valid stays 1. The valid signal never drops while stalled.
    - Handshake on window (OUT_H-1, OUT_W-1) -> DONE. win_valid=0 and busy=0 next cycle.
  - DONE: done=1 for exactly one cycle -> IDLE.
- start is ignored in SCAN and DONE; no restart and no queuing. start in the same cycle the block returns to IDLE is honoured only in IDLE.
- Window bits are a pure index function of the current counters. The block never writes or latches the pixel array. If pixels changes mid-scan, later windows reflect the new data; that is a caller error, not guarded.
- Counters never exceed OUT_H-1/OUT_W-1; no wrap past the last window.
- Defaults: start->done with win_ready constantly 1 = 677 cycles (windows in cycles 1..676, done in 677).

Optional Feature:
- Macro: BNN_WINDOW_ZERO_PAD_EN.
- Defined: "same" padding. Output grid is IMG_H x IMG_W (784 windows). Window (r,c) is centred on pixel(r,c): win[K*i+j] = pixel(r-(K/2)+i, c-(K/2)+j). Out-of-image positions read 0. Counter widths are unchanged. Start->done under full ready = 785 cycles.
- Undefined: valid-only grid as above; no padding logic synthesised.

Decomposition:
- Shared package bnn_pkg:
  - IMG_H, IMG_W, K defaults.
  - Derived OUT_H/OUT_W localparams.
  - typedef enum for reader state {IDLE, SCAN, DONE}.
  - Row/col index typedefs sized with $clog2, reused by layer 1.
- One sub-module: bnn_window_mux. Combinational; takes pixels plus row/col and returns the KxK window, with padding under the macro. The reader instantiates it once, feeding next-counter values.

Test Plan:
1. Only pixel(0,0)=1, start, win_ready=1 -> window (0,0) win=9'b000000001 at cycle 1; all other 675 windows win=0; done pulse at cycle 677; busy low at 677.
2. Only pixel(27,27)=1 -> only window (25,25) has win=9'b100000000; exactly 676 handshakes; row/col sequence strictly raster.
3. Checkerboard pixels, win_ready toggling 1,0,1,0 -> while stalled, win/win_row/win_col stable and win_valid=1; 676 handshakes; every window matches the scoreboard model; done 1 cycle wide.
4. start pulsed again at window 100 -> ignored, scan continues. Assert rst at window 200 -> win_valid, busy, done = 0 immediately. Release rst and start -> first window is (0,0).
5. BNN_WINDOW_ZERO_PAD_EN defined, only pixel(0,0)=1 -> window (0,0) win=9'b000010000, window (0,1) win=9'b000001000, window (1,1) win=9'b000000001; 784 windows; last window (27,27); done at cycle 785.
6. All-ones pixels, no padding -> every window 9'h1FF. With the macro, window (0,0)=9'b110110000 and window (27,27)=9'b000011011.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN layer-1 input path: image geometry, output grid,
// reader state encoding and row/column index types. Honours BNN_WINDOW_ZERO_PAD_EN.
package bnn_pkg;

  localparam int IMG_H = 28;
  localparam int IMG_W = 28;
  localparam int K     = 3;

  // "Same" padding keeps the output grid the size of the image.
`ifdef BNN_WINDOW_ZERO_PAD_EN
  localparam int OUT_H = IMG_H;
  localparam int OUT_W = IMG_W;
`else
  localparam int OUT_H = IMG_H - K + 1;
  localparam int OUT_W = IMG_W - K + 1;
`endif

  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);

  typedef logic [ROW_W-1:0] row_idx_t;
  typedef logic [COL_W-1:0] col_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } reader_state_e;

  // Output-grid edge for a given image edge, matching the padding build option.
  function automatic int out_dim(input int img_dim, input int k);
`ifdef BNN_WINDOW_ZERO_PAD_EN
    return img_dim;
`else
    return img_dim - k + 1;
`endif
  endfunction

endpackage

// File: rtl/bnn_window_mux.sv
// Combinational KxK window selector over the flattened binary pixel array.
// With BNN_WINDOW_ZERO_PAD_EN the window is centred on (row,col) and off-image taps read 0.
module bnn_window_mux
  import bnn_pkg::*;
#(
  parameter int IMG_H = bnn_pkg::IMG_H,
  parameter int IMG_W = bnn_pkg::IMG_W,
  parameter int K     = bnn_pkg::K,
  parameter int ROW_W = $clog2(IMG_H),
  parameter int COL_W = $clog2(IMG_W)
) (
  input  logic [IMG_H*IMG_W-1:0] pixels,
  input  logic [ROW_W-1:0]       row,
  input  logic [COL_W-1:0]       col,
  output logic [K*K-1:0]         win
);

  localparam int PIX_W = $clog2(IMG_H*IMG_W);

`ifdef BNN_WINDOW_ZERO_PAD_EN
  localparam int OFS = K / 2;
`else
  localparam int OFS = 0;
`endif

  // NOTE: every output and temporary gets a value before any conditional path,
  // so this block can never infer a latch.
  always_comb begin
    int pr;
    int pc;
    win = '0;
    pr  = 0;
    pc  = 0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        pr = int'(row) + i - OFS;
        pc = int'(col) + j - OFS;
`ifdef BNN_WINDOW_ZERO_PAD_EN
        if (pr >= 0 && pr < IMG_H && pc >= 0 && pc < IMG_W)
          win[K*i+j] = pixels[PIX_W'(pr*IMG_W + pc)];
`else
        win[K*i+j] = pixels[PIX_W'(pr*IMG_W + pc)];
`endif
      end
    end
  end

endmodule

// File: rtl/bnn_window_reader.sv
// Raster-order KxK window reader feeding layer 1 with a valid/ready handshake.
// Optional "same" padding via BNN_WINDOW_ZERO_PAD_EN.
module bnn_window_reader #(
  parameter int IMG_H = bnn_pkg::IMG_H,
  parameter int IMG_W = bnn_pkg::IMG_W,
  parameter int K     = bnn_pkg::K
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [IMG_H*IMG_W-1:0]     pixels,
  input  logic                       win_ready,
  output logic                       win_valid,
  output logic [K*K-1:0]             win,
  output logic [$clog2(IMG_H)-1:0]   win_row,
  output logic [$clog2(IMG_W)-1:0]   win_col,
  output logic                       busy,
  output logic                       done
);

  import bnn_pkg::*;

  localparam int RW    = $clog2(IMG_H);
  localparam int CW    = $clog2(IMG_W);
  localparam int OH    = out_dim(IMG_H, K);
  localparam int OW    = out_dim(IMG_W, K);

  localparam logic [RW-1:0] ROW_LAST = RW'(OH - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(OW - 1);

  reader_state_e   state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [K*K-1:0]  win_q, win_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            load;
  logic            handshake;
  logic [K*K-1:0]  mux_win;

  // The mux sees next-counter values so the window lands in the same edge as its indices.
  bnn_window_mux #(
    .IMG_H (IMG_H),
    .IMG_W (IMG_W),
    .K     (K),
    .ROW_W (RW),
    .COL_W (CW)
  ) u_mux (
    .pixels (pixels),
    .row    (row_d),
    .col    (col_d),
    .win    (mux_win)
  );

  assign handshake = valid_q && win_ready;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          row_d   = '0;
          col_d   = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          load    = 1'b1;
        end
      end

      SCAN: begin
        if (handshake) begin
          if (row_q == ROW_LAST && col_q == COL_LAST) begin
            state_d = DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            load = 1'b1;
            if (col_q == COL_LAST) begin
              col_d = '0;
              row_d = row_q + RW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // Stalled windows hold their bits even if the pixel bus wiggles.
    win_d = load ? mux_win : win_q;
  end

  // NOTE: non-blocking assignments here so every flop samples pre-edge values,
  // independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign win_valid = valid_q;
  assign win       = win_q;
  assign win_row   = row_q;
  assign win_col   = col_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_bnn_window_reader.sv
// Self-checking bench for bnn_window_reader: randomized images and ready patterns
// compared against a 2-D image model; honours BNN_WINDOW_ZERO_PAD_EN.
module tb_bnn_window_reader;

  localparam int IMG_H = 28;
  localparam int IMG_W = 28;
  localparam int K     = 3;
  localparam int RW    = $clog2(IMG_H);
  localparam int CW    = $clog2(IMG_W);
`ifdef BNN_WINDOW_ZERO_PAD_EN
  localparam int OUT_H = IMG_H;
  localparam int OUT_W = IMG_W;
  localparam int P     = K / 2;
`else
  localparam int OUT_H = IMG_H - K + 1;
  localparam int OUT_W = IMG_W - K + 1;
  localparam int P     = 0;
`endif
  localparam int TOTAL = OUT_H * OUT_W;

  logic                     clk;
  logic                     rst;
  logic                     start;
  logic [IMG_H*IMG_W-1:0]   pixels;
  logic                     win_ready;
  logic                     win_valid;
  logic [K*K-1:0]           win;
  logic [RW-1:0]            win_row;
  logic [CW-1:0]            win_col;
  logic                     busy;
  logic                     done;

  int checks;
  int errors;

  bit img [IMG_H][IMG_W];

  bnn_window_reader #(.IMG_H(IMG_H), .IMG_W(IMG_W), .K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pixels    (pixels),
    .win_ready (win_ready),
    .win_valid (win_valid),
    .win       (win),
    .win_row   (win_row),
    .win_col   (win_col),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic clear_img();
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[r][c] = 1'b0;
  endtask

  task automatic pack_img();
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        pixels[r*IMG_W + c] = img[r][c];
  endtask

  function automatic bit img_at(input int r, input int c);
    if (r < 0 || r >= IMG_H || c < 0 || c >= IMG_W) return 1'b0;
    return img[r][c];
  endfunction

  function automatic logic [K*K-1:0] exp_win(input int r, input int c);
    logic [K*K-1:0] w;
    w = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        w[K*i+j] = img_at(r - P + i, c - P + j);
    return w;
  endfunction

  // mode: 0 = ready always, 1 = ready toggling 1,0,1,0, 2 = random ready.
  // restart_at / rst_at: window ordinal at which to pulse start / assert reset (-1 = never).
  task automatic do_scan(input int mode, input int restart_at, input int rst_at,
                         output int done_cyc);
    int idx, cyc, er, ec;
    bit fin, rdy, restarted;
    logic [K*K-1:0] ew;
    done_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    win_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; idx = 0; fin = 1'b0; restarted = 1'b0;
    while (!fin) begin
      if (cyc > 4*TOTAL + 10) begin
        checks++; errors++;
        $display("FAIL scan_timeout: idx=%0d handshakes, required %0d", idx, TOTAL);
        break;
      end
      if (idx < TOTAL) begin
        er = idx / OUT_W;
        ec = idx % OUT_W;
        ew = exp_win(er, ec);
        checks++;
        if (win_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL scan_flags cyc=%0d: valid=%b busy=%b done=%b, required 1 1 0",
                   cyc, win_valid, busy, done);
        end
        checks++;
        if (win_row !== RW'(er) || win_col !== CW'(ec)) begin
          errors++;
          $display("FAIL scan_index cyc=%0d: got (%0d,%0d), required (%0d,%0d)",
                   cyc, win_row, win_col, er, ec);
        end
        checks++;
        if (win !== ew) begin
          errors++;
          $display("FAIL scan_window (%0d,%0d): got %b, required %b", er, ec, win, ew);
        end
        if (idx == rst_at) begin
          rst = 1'b1;
          #1;
          checks++;
          if (win_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
              win !== '0 || win_row !== '0 || win_col !== '0) begin
            errors++;
            $display("FAIL midscan_reset: valid=%b busy=%b done=%b win=%b row=%0d col=%0d, required all 0",
                     win_valid, busy, done, win, win_row, win_col);
          end
          @(negedge clk);
          rst = 1'b0;
          win_ready = 1'b0;
          return;
        end
        if (idx == restart_at && !restarted) begin
          start = 1'b1;
          restarted = 1'b1;
        end
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = (cyc % 2) == 1;
          default: rdy = ($urandom_range(0, 3) != 0);
        endcase
        win_ready = rdy;
        if (rdy) idx++;
      end else begin
        checks++;
        if (done !== 1'b1 || win_valid !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL done_pulse cyc=%0d: done=%b valid=%b busy=%b, required 1 0 0",
                   cyc, done, win_valid, busy);
        end
        done_cyc = cyc;
        fin = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || win_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_width: done=%b busy=%b valid=%b after done cycle, required 0 0 0",
               done, busy, win_valid);
    end
    win_ready = 1'b0;
  endtask

  task automatic check_done_cycle(input string name, input int got);
    checks++;
    if (got !== TOTAL + 1) begin
      errors++;
      $display("FAIL %s_latency: done at cycle %0d, required %0d", name, got, TOTAL + 1);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; win_ready = 1'b0; pixels = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (win_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        win !== '0 || win_row !== '0 || win_col !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b busy=%b done=%b win=%b row=%0d col=%0d, required all 0",
               win_valid, busy, done, win, win_row, win_col);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (win_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: valid=%b busy=%b, required 0 0", win_valid, busy);
    end
  endtask

  task automatic test_first_pixel();
    int dc;
    clear_img(); img[0][0] = 1'b1; pack_img();
    do_scan(0, -1, -1, dc);
    check_done_cycle("first_pixel", dc);
  endtask

  task automatic test_last_pixel();
    int dc;
    clear_img(); img[IMG_H-1][IMG_W-1] = 1'b1; pack_img();
    do_scan(0, -1, -1, dc);
    check_done_cycle("last_pixel", dc);
  endtask

  task automatic test_checker_stall();
    int dc;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[r][c] = ((r + c) % 2) == 0;
    pack_img();
    do_scan(1, -1, -1, dc);
  endtask

  task automatic test_random_stall();
    int dc;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[r][c] = $urandom_range(0, 1);
    pack_img();
    do_scan(2, -1, -1, dc);
  endtask

  task automatic test_restart_and_reset();
    int dc;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[r][c] = $urandom_range(0, 1);
    pack_img();
    do_scan(0, 100, 200, dc);
    do_scan(0, -1, -1, dc);
    check_done_cycle("after_reset", dc);
  endtask

  task automatic test_all_ones();
    int dc;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[r][c] = 1'b1;
    pack_img();
    do_scan(0, -1, -1, dc);
    check_done_cycle("all_ones", dc);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_first_pixel();
    test_last_pixel();
    test_checker_stall();
    test_random_stall();
    test_restart_and_reset();
    test_all_ones();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
